// File: rtl/vga_timing_gen_if.sv
// Video timing bus: config handshake in, timing/strobes/fetch requests out.
// master: the framebuffer/host side (drives cfg_*, observes timing).
// slave:  the timing generator.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 12
);
    logic             cfg_vld;
    logic [CNT_W-1:0] cfg_x_active;
    logic [CNT_W-1:0] cfg_y_active;
    logic             cfg_rdy;
    logic             cfg_pending;
    logic             pix_ce;
    logic             hsync;
    logic             vsync;
    logic             display;
    logic [CNT_W-1:0] x_coord;
    logic [CNT_W-1:0] y_coord;
    logic             row_done;
    logic             frame_done;
    logic             fetch_vld;
    logic [CNT_W-1:0] fetch_x;

    modport master (
        output cfg_vld, cfg_x_active, cfg_y_active,
        input  cfg_rdy, cfg_pending, pix_ce, hsync, vsync, display,
               x_coord, y_coord, row_done, frame_done, fetch_vld, fetch_x
    );

    modport slave (
        input  cfg_vld, cfg_x_active, cfg_y_active,
        output cfg_rdy, cfg_pending, pix_ce, hsync, vsync, display,
               x_coord, y_coord, row_done, frame_done, fetch_vld, fetch_x
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock-enable divider,
// lead-ahead fetch strobe and frame-boundary active-size reprogramming.
// Ports: clk, rst_n (synchronous, active low), bus (vga_timing_gen_if.slave):
//   cfg_vld/cfg_x_active/cfg_y_active/cfg_rdy/cfg_pending  size handshake
//   pix_ce                                                 pixel tick
//   hsync/vsync/display/x_coord/y_coord                    video timing
//   row_done/frame_done                                    end-of-line/frame
//   fetch_vld/fetch_x                                      framebuffer fetch
module vga_timing_gen #(
    parameter int unsigned X_ACTIVE      = 800,
    parameter int unsigned X_FRONT_PORCH = 56,
    parameter int unsigned X_SYNC_PULSE  = 128,
    parameter int unsigned X_BACK_PORCH  = 64,
    parameter int unsigned X_POL         = 1,
    parameter int unsigned Y_ACTIVE      = 600,
    parameter int unsigned Y_FRONT_PORCH = 37,
    parameter int unsigned Y_SYNC_PULSE  = 6,
    parameter int unsigned Y_BACK_PORCH  = 23,
    parameter int unsigned Y_POL         = 1,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned LEAD          = 2,
    parameter int unsigned CNT_W         = 12
) (
    input logic             clk,
    input logic             rst_n,
    vga_timing_gen_if.slave bus
);
    localparam int unsigned H_BLK = X_FRONT_PORCH + X_SYNC_PULSE + X_BACK_PORCH;
    localparam int unsigned V_BLK = Y_FRONT_PORCH + Y_SYNC_PULSE + Y_BACK_PORCH;
    localparam int unsigned X_MAX = (1 << CNT_W) - 1 - H_BLK;
    localparam int unsigned Y_MAX = (1 << CNT_W) - 1 - V_BLK;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FT_W  = CNT_W + 1;
    localparam logic        HS_ON = 1'(X_POL);
    localparam logic        VS_ON = 1'(Y_POL);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_act_q, x_act_d, y_act_q, y_act_d;
    logic [CNT_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic             cfg_pending_q, cfg_pending_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, display_q, display_d;
    logic [CNT_W-1:0] x_coord_q, x_coord_d, y_coord_q, y_coord_d;
    logic             row_done_q, row_done_d, frame_done_q, frame_done_d;
    logic             fetch_vld_q, fetch_vld_d;
    logic [CNT_W-1:0] fetch_x_q, fetch_x_d;

    logic             pix_ce_c, h_last_c, v_last_c, in_act_c, stb_c;
    logic [CNT_W-1:0] h_tot_c, v_tot_c, fl_c;
    logic [FT_W-1:0]  ft_c;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] hi);
        if (v == '0) return CNT_W'(1);
        if (v > hi)  return hi;
        return v;
    endfunction

    // Next-state: divider, counters, config shadow, registered decodes
    always_comb begin
        pix_ce_c = (div_q == DIV_W'(CLK_DIV - 1));
        h_tot_c  = x_act_q + CNT_W'(H_BLK);
        v_tot_c  = y_act_q + CNT_W'(V_BLK);
        h_last_c = (h_cnt_q == h_tot_c - 1'b1);
        v_last_c = (v_cnt_q == v_tot_c - 1'b1);
        in_act_c = (h_cnt_q < x_act_q) && (v_cnt_q < y_act_q);
        // Counters changed on the previous edge (or just left reset):
        // single-clk strobes fire only on this first decode of a position.
        stb_c    = (div_q == '0);

        div_d         = pix_ce_c ? '0 : div_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_act_d       = x_act_q;
        y_act_d       = y_act_q;
        sh_x_d        = sh_x_q;
        sh_y_d        = sh_y_q;
        cfg_pending_d = cfg_pending_q;

        if (pix_ce_c) begin
            if (h_last_c) begin
                h_cnt_d = '0;
                v_cnt_d = v_last_c ? '0 : v_cnt_q + 1'b1;
                // Frame wrap: swap in the shadow size atomically.
                if (v_last_c && cfg_pending_q) begin
                    x_act_d       = sh_x_q;
                    y_act_d       = sh_y_q;
                    cfg_pending_d = 1'b0;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        // Pending blocks acceptance, including on the applying clk.
        if (bus.cfg_vld && !cfg_pending_q) begin
            sh_x_d        = clamp(bus.cfg_x_active, CNT_W'(X_MAX));
            sh_y_d        = clamp(bus.cfg_y_active, CNT_W'(Y_MAX));
            cfg_pending_d = 1'b1;
        end

        hsync_d = ((h_cnt_q >= x_act_q + CNT_W'(X_FRONT_PORCH)) &&
                   (h_cnt_q <  x_act_q + CNT_W'(X_FRONT_PORCH + X_SYNC_PULSE)))
                  ? HS_ON : ~HS_ON;
        vsync_d = ((v_cnt_q >= y_act_q + CNT_W'(Y_FRONT_PORCH)) &&
                   (v_cnt_q <  y_act_q + CNT_W'(Y_FRONT_PORCH + Y_SYNC_PULSE)))
                  ? VS_ON : ~VS_ON;
        display_d    = in_act_c;
        x_coord_d    = in_act_c ? h_cnt_q : '0;
        y_coord_d    = in_act_c ? v_cnt_q : '0;
        row_done_d   = stb_c && in_act_c && (h_cnt_q == x_act_q - 1'b1);
        frame_done_d = row_done_d && (v_cnt_q == y_act_q - 1'b1);

        // Fetch target LEAD ticks ahead; LEAD never exceeds blanking,
        // so at most one line wrap is possible.
        ft_c = {1'b0, h_cnt_q} + FT_W'(LEAD);
        fl_c = v_cnt_q;
        if (ft_c >= {1'b0, h_tot_c}) begin
            ft_c = ft_c - {1'b0, h_tot_c};
            fl_c = v_last_c ? '0 : v_cnt_q + 1'b1;
        end
        fetch_vld_d = stb_c && (ft_c < {1'b0, x_act_q}) && (fl_c < y_act_q);
        fetch_x_d   = fetch_vld_d ? ft_c[CNT_W-1:0] : '0;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_act_q       <= CNT_W'(X_ACTIVE);
            y_act_q       <= CNT_W'(Y_ACTIVE);
            sh_x_q        <= CNT_W'(X_ACTIVE);
            sh_y_q        <= CNT_W'(Y_ACTIVE);
            cfg_pending_q <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            display_q     <= 1'b0;
            x_coord_q     <= '0;
            y_coord_q     <= '0;
            row_done_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            fetch_vld_q   <= 1'b0;
            fetch_x_q     <= '0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_act_q       <= x_act_d;
            y_act_q       <= y_act_d;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            cfg_pending_q <= cfg_pending_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            x_coord_q     <= x_coord_d;
            y_coord_q     <= y_coord_d;
            row_done_q    <= row_done_d;
            frame_done_q  <= frame_done_d;
            fetch_vld_q   <= fetch_vld_d;
            fetch_x_q     <= fetch_x_d;
        end
    end

    assign bus.cfg_rdy     = ~cfg_pending_q;
    assign bus.cfg_pending = cfg_pending_q;
    assign bus.pix_ce      = pix_ce_c;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.display     = display_q;
    assign bus.x_coord     = x_coord_q;
    assign bus.y_coord     = y_coord_q;
    assign bus.row_done    = row_done_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.fetch_vld   = fetch_vld_q;
    assign bus.fetch_x     = fetch_x_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (CLK_DIV=2 and 1)
// checked every clk against a linear tick-index model, plus literal
// per-frame counts for default, reprogrammed, clamped and reset cases.
module tb_vga_timing_gen;
    localparam int unsigned CNT_W = 6;
    localparam int XA = 8, XFP = 3, XSP = 4, XBP = 2;
    localparam int YA = 5, YFP = 2, YSP = 2, YBP = 1;
    localparam int LEAD = 2;
    localparam bit XPOL = 1'b1, YPOL = 1'b0;
    localparam int H_BLK = XFP + XSP + XBP;
    localparam int V_BLK = YFP + YSP + YBP;
    localparam int XMAX = (1 << CNT_W) - 1 - H_BLK;
    localparam int YMAX = (1 << CNT_W) - 1 - V_BLK;

    typedef struct packed {
        logic             ce, rdy, pend, hs, vs, disp;
        logic [CNT_W-1:0] x, y;
        logic             row, frame, fv;
        logic [CNT_W-1:0] fx;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_vld = 1'b0;
    logic [CNT_W-1:0] cfg_x = '0, cfg_y = '0;
    int               checks = 0, errors = 0, cyc = 0;
    bit               started = 1'b0;

    vga_timing_gen_if #(.CNT_W(CNT_W)) bus0 ();
    vga_timing_gen_if #(.CNT_W(CNT_W)) bus1 ();
    assign bus0.cfg_vld = cfg_vld;  assign bus1.cfg_vld = cfg_vld;
    assign bus0.cfg_x_active = cfg_x;  assign bus1.cfg_x_active = cfg_x;
    assign bus0.cfg_y_active = cfg_y;  assign bus1.cfg_y_active = cfg_y;

    vga_timing_gen #(.X_ACTIVE(XA), .X_FRONT_PORCH(XFP), .X_SYNC_PULSE(XSP),
        .X_BACK_PORCH(XBP), .X_POL(1), .Y_ACTIVE(YA), .Y_FRONT_PORCH(YFP),
        .Y_SYNC_PULSE(YSP), .Y_BACK_PORCH(YBP), .Y_POL(0), .CLK_DIV(2),
        .LEAD(LEAD), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    vga_timing_gen #(.X_ACTIVE(XA), .X_FRONT_PORCH(XFP), .X_SYNC_PULSE(XSP),
        .X_BACK_PORCH(XBP), .X_POL(1), .Y_ACTIVE(YA), .Y_FRONT_PORCH(YFP),
        .Y_SYNC_PULSE(YSP), .Y_BACK_PORCH(YBP), .Y_POL(0), .CLK_DIV(1),
        .LEAD(LEAD), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycles=%0d limit=50000", cyc);
            $fatal(1);
        end
    end

    // ---------------- model: position as a linear tick index in the frame
    int   mc[2], mk[2], mxa[2], mya[2], msx[2], msy[2];
    bit   mpend[2], macc;
    obs_t exp_o[2], act[2];

    function automatic int cdiv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int clampv(input int v, input int hi);
        return (v == 0) ? 1 : ((v > hi) ? hi : v);
    endfunction

    function automatic obs_t decode(input int k, input int xa, input int ya, input bit stb);
        obs_t o;
        int ht, vt, h, v, tk, th, tv;
        ht = xa + H_BLK;  vt = ya + V_BLK;
        h  = k % ht;      v  = k / ht;
        tk = (k + LEAD) % (ht * vt);
        th = tk % ht;     tv = tk / ht;
        o = '0;
        o.hs   = (h >= xa + XFP && h < xa + XFP + XSP) ? XPOL : ~XPOL;
        o.vs   = (v >= ya + YFP && v < ya + YFP + YSP) ? YPOL : ~YPOL;
        o.disp = (h < xa) && (v < ya);
        if (o.disp) begin
            o.x = CNT_W'(h);
            o.y = CNT_W'(v);
        end
        o.row   = stb && o.disp && (h == xa - 1);
        o.frame = o.row && (v == ya - 1);
        o.fv    = stb && (th < xa) && (tv < ya);
        if (o.fv) o.fx = CNT_W'(th);
        return o;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mc[i] = 0;  mk[i] = 0;  mpend[i] = 1'b0;
                mxa[i] = XA;  mya[i] = YA;
                exp_o[i]     = '0;
                exp_o[i].hs  = ~XPOL;
                exp_o[i].vs  = ~YPOL;
                exp_o[i].rdy = 1'b1;
                exp_o[i].ce  = (cdiv(i) == 1);
            end else begin
                exp_o[i] = decode(mk[i], mxa[i], mya[i], (mc[i] % cdiv(i)) == 0);
                macc = cfg_vld && !mpend[i];
                if (mc[i] % cdiv(i) == cdiv(i) - 1) begin
                    mk[i]++;
                    if (mk[i] == (mxa[i] + H_BLK) * (mya[i] + V_BLK)) begin
                        mk[i] = 0;
                        if (mpend[i]) begin
                            mxa[i] = msx[i];  mya[i] = msy[i];  mpend[i] = 1'b0;
                        end
                    end
                end
                if (macc) begin
                    msx[i] = clampv(int'(cfg_x), XMAX);
                    msy[i] = clampv(int'(cfg_y), YMAX);
                    mpend[i] = 1'b1;
                end
                mc[i]++;
                exp_o[i].ce   = (mc[i] % cdiv(i)) == cdiv(i) - 1;
                exp_o[i].rdy  = !mpend[i];
                exp_o[i].pend = mpend[i];
            end
        end
        started = 1'b1;
    end

    // ---------------- per-clk compare of both instances
    always @(negedge clk) begin
        if (started) begin
            act[0] = {bus0.pix_ce, bus0.cfg_rdy, bus0.cfg_pending, bus0.hsync, bus0.vsync,
                      bus0.display, bus0.x_coord, bus0.y_coord, bus0.row_done,
                      bus0.frame_done, bus0.fetch_vld, bus0.fetch_x};
            act[1] = {bus1.pix_ce, bus1.cfg_rdy, bus1.cfg_pending, bus1.hsync, bus1.vsync,
                      bus1.display, bus1.x_coord, bus1.y_coord, bus1.row_done,
                      bus1.frame_done, bus1.fetch_vld, bus1.fetch_x};
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL dut%0d_outputs cyc=%0d: got=%h expected=%h",
                             i, cyc, act[i], exp_o[i]);
                end
            end
        end
    end

    // ---------------- literal checks
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.frame_done && n < 2000);
        if (!bus0.frame_done) begin
            errors++;  checks++;
            $display("FAIL wait_frame_done: got timeout after %0d clks expected pulse", n);
        end
    endtask

    // Counts one full dut0 frame, from just after a frame_done to the next.
    task automatic measure(input string tag, input int e_rows, input int e_fet,
                           input int e_hs, input int e_per, input int e_lx,
                           input int e_ly, input int e_fd1);
        int rows, fet, hs, per, fd1;
        bit done;
        rows = 0; fet = 0; hs = 0; per = 0; fd1 = 0; done = 1'b0;
        while (!done && per < 4000) begin
            @(negedge clk);
            per++;
            rows += int'(bus0.row_done);
            fet  += int'(bus0.fetch_vld);
            hs   += int'(bus0.hsync == XPOL);
            fd1  += int'(bus1.frame_done);
            if (bus0.row_done) check({tag, "_row_x"}, int'(bus0.x_coord), e_lx);
            if (bus0.frame_done) begin
                done = 1'b1;
                check({tag, "_last_y"}, int'(bus0.y_coord), e_ly);
            end
        end
        check({tag, "_period"}, per, e_per);
        check({tag, "_rows"}, rows, e_rows);
        check({tag, "_fetches"}, fet, e_fet);
        check({tag, "_hsync_clks"}, hs, e_hs);
        if (e_fd1 >= 0) check({tag, "_div1_frames"}, fd1, e_fd1);
    endtask

    task automatic send_cfg(input int x, input int y);
        cfg_x = CNT_W'(x);  cfg_y = CNT_W'(y);  cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hsync", int'(bus0.hsync), 0);
        check("rst_vsync", int'(bus0.vsync), 1);
        check("rst_cfg_rdy", int'(bus0.cfg_rdy), 1);
        check("rst_display", int'(bus0.display), 0);
        check("rst_pix_ce_div2", int'(bus0.pix_ce), 0);
        check("rst_pix_ce_div1", int'(bus1.pix_ce), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_pix_ce", int'(bus0.pix_ce), 1);
        check("first_display", int'(bus0.display), 1);

        // default 8x5: H_TOT 17, V_TOT 10, 170 ticks = 340 clks
        wait_fd();
        measure("dflt", 5, 40, 80, 340, 7, 4, 2);

        // reprogram to 4x3; the 6x6 offered while pending must be dropped
        send_cfg(4, 3);
        check("cfg_pending_set", int'(bus0.cfg_pending), 1);
        check("cfg_rdy_low", int'(bus0.cfg_rdy), 0);
        send_cfg(6, 6);
        check("cfg_still_pending", int'(bus0.cfg_pending), 1);
        wait_fd();
        // 13 x 8 = 104 ticks
        measure("cfg4x3", 3, 12, 64, 208, 3, 2, -1);
        check("cfg_pending_clear", int'(bus0.cfg_pending), 0);
        check("cfg_rdy_back", int'(bus0.cfg_rdy), 1);

        // out-of-range request clamps to 54x1: 63 x 6 = 378 ticks
        send_cfg(60, 0);
        wait_fd();
        measure("clamp", 1, 54, 48, 756, 53, 0, -1);

        // reset mid-frame with a pending config
        send_cfg(4, 3);
        repeat (100) @(negedge clk);
        check("pre_rst_pending", int'(bus0.cfg_pending), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pending", int'(bus0.cfg_pending), 0);
        check("mid_rst_display", int'(bus0.display), 0);
        check("mid_rst_hsync", int'(bus0.hsync), 0);
        check("mid_rst_vsync", int'(bus0.vsync), 1);
        check("mid_rst_x", int'(bus0.x_coord), 0);
        rst_n = 1'b1;
        wait_fd();
        measure("post_rst", 5, 40, 80, 340, 7, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
